clock_cnt_duty_bus_if: RTL and testbench

CLOCK_CNT_DUTY_BUS_IF -- requirements
Module: clock_cnt_duty_bus_if

---
 rtl/bus_if_pkg.sv | 17 +
 rtl/sdp_ram.sv | 40 ++++
 rtl/clock_cnt_duty_bus_if.sv | 115 +++++++++++
 tb/tb_clock_cnt_duty_bus_if.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bus_if_pkg.sv
// Shared encodings and sizes for the clock/cnt/duty host bus.
// Imported by the RAM sub-module and the bus top.
package bus_if_pkg;

    localparam int DATA_W        = 16;
    localparam int CNT_DEPTH_DEF = 64;
    localparam int CLK_DEPTH_DEF = 64;
    localparam int DUTY_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        SEL_CNT  = 2'd0,
        SEL_CLK  = 2'd1,
        SEL_DUTY = 2'd2,
        SEL_RSV  = 2'd3
    } sel_e;

endpackage

// File: rtl/sdp_ram.sv
// One write port, two enabled read ports, 1-cycle registered read.
// Contents are never reset; only the read registers clear.
module sdp_ram
    import bus_if_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              a_en,
    input  logic [AW-1:0]     a_addr,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_en,
    input  logic [AW-1:0]     b_addr,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; no reset so table contents survive RST.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read registers see pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_en) a_data <= mem[a_addr];
            if (b_en) b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/clock_cnt_duty_bus_if.sv
// Host bus into cnt register file, clock-config table and duty table,
// with independent 1-cycle read ports for the consumers.
module clock_cnt_duty_bus_if
    import bus_if_pkg::*;
#(
    parameter int CNT_DEPTH  = CNT_DEPTH_DEF,
    parameter int CLK_DEPTH  = CLK_DEPTH_DEF,
    parameter int DUTY_DEPTH = DUTY_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HOST_EN,
    input  logic              HOST_WE,
    input  logic [1:0]        HOST_SEL,
    input  logic [13:0]       HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_DIN,
    output logic [DATA_W-1:0] HOST_DOUT,
    input  logic [5:0]        CLK_IDX,
    output logic [DATA_W-1:0] CLK_DOUT,
    input  logic [5:0]        CNT_ADDR,
    input  logic              CNT_WE,
    input  logic [DATA_W-1:0] CNT_DIN,
    output logic [DATA_W-1:0] CNT_DOUT,
    input  logic [9:0]        DUTY_IDX,
    output logic [DATA_W-1:0] DUTY_DOUT
);

    localparam int CNT_AW  = $clog2(CNT_DEPTH);
    localparam int CLK_AW  = $clog2(CLK_DEPTH);
    localparam int DUTY_AW = $clog2(DUTY_DEPTH);

    sel_e              host_sel;
    sel_e              sel_q;
    logic              host_wr;
    logic              host_rd;
    logic [CNT_AW-1:0] host_cnt_a;
    logic [CNT_AW-1:0] cnt_a;
    logic [DATA_W-1:0] cnt_q [CNT_DEPTH];
    logic [DATA_W-1:0] cnt_host_q;
    logic [DATA_W-1:0] clk_host_data;
    logic [DATA_W-1:0] duty_host_data;
    logic              unused_bits;

    // Address bits above each target's depth are dropped (wrap).
    assign unused_bits = ^{HOST_ADDR, CLK_IDX, CNT_ADDR, DUTY_IDX};

    assign host_sel   = sel_e'(HOST_SEL);
    assign host_wr    = HOST_EN && HOST_WE && !RST;
    assign host_rd    = HOST_EN && !HOST_WE && !RST;
    assign host_cnt_a = HOST_ADDR[CNT_AW-1:0];
    assign cnt_a      = CNT_ADDR[CNT_AW-1:0];

    sdp_ram #(.DEPTH(CLK_DEPTH)) u_clk_ram (
        .clk    (CLK),
        .rst    (RST),
        .we     (host_wr && host_sel == SEL_CLK),
        .waddr  (HOST_ADDR[CLK_AW-1:0]),
        .wdata  (HOST_DIN),
        .a_en   (host_rd && host_sel == SEL_CLK),
        .a_addr (HOST_ADDR[CLK_AW-1:0]),
        .a_data (clk_host_data),
        .b_en   (1'b1),
        .b_addr (CLK_IDX[CLK_AW-1:0]),
        .b_data (CLK_DOUT)
    );

    sdp_ram #(.DEPTH(DUTY_DEPTH)) u_duty_ram (
        .clk    (CLK),
        .rst    (RST),
        .we     (host_wr && host_sel == SEL_DUTY),
        .waddr  (HOST_ADDR[DUTY_AW-1:0]),
        .wdata  (HOST_DIN),
        .a_en   (host_rd && host_sel == SEL_DUTY),
        .a_addr (HOST_ADDR[DUTY_AW-1:0]),
        .a_data (duty_host_data),
        .b_en   (1'b1),
        .b_addr (DUTY_IDX[DUTY_AW-1:0]),
        .b_data (DUTY_DOUT)
    );

    // Cnt register file: host write is applied last so it wins a collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CNT_DEPTH; i++) cnt_q[i] <= '0;
            CNT_DOUT   <= '0;
            cnt_host_q <= '0;
        end else begin
            CNT_DOUT <= cnt_q[cnt_a];
            if (host_rd && host_sel == SEL_CNT)
                cnt_host_q <= cnt_q[host_cnt_a];
            if (CNT_WE)
                cnt_q[cnt_a] <= CNT_DIN;
            if (host_wr && host_sel == SEL_CNT)
                cnt_q[host_cnt_a] <= HOST_DIN;
        end
    end

    // Remember which target the last host read hit, so HOST_DOUT holds.
    always_ff @(posedge CLK) begin
        if (RST)          sel_q <= SEL_CNT;
        else if (host_rd) sel_q <= host_sel;
    end

    // Host read mux over the held per-target read registers.
    always_comb begin
        HOST_DOUT = '0;
        unique case (sel_q)
            SEL_CNT:  HOST_DOUT = cnt_host_q;
            SEL_CLK:  HOST_DOUT = clk_host_data;
            SEL_DUTY: HOST_DOUT = duty_host_data;
            SEL_RSV:  HOST_DOUT = '0;
        endcase
    end

endmodule

// File: tb/tb_clock_cnt_duty_bus_if.sv
// Directed bench for clock_cnt_duty_bus_if.
// Hand-computed expectations, one check task.
module tb_clock_cnt_duty_bus_if;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        HOST_EN = 1'b0;
    logic        HOST_WE = 1'b0;
    logic [1:0]  HOST_SEL = 2'd0;
    logic [13:0] HOST_ADDR = '0;
    logic [15:0] HOST_DIN = '0;
    logic [15:0] HOST_DOUT;
    logic [5:0]  CLK_IDX = '0;
    logic [15:0] CLK_DOUT;
    logic [5:0]  CNT_ADDR = 6'd5;
    logic        CNT_WE = 1'b0;
    logic [15:0] CNT_DIN = '0;
    logic [15:0] CNT_DOUT;
    logic [9:0]  DUTY_IDX = '0;
    logic [15:0] DUTY_DOUT;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] rd;

    clock_cnt_duty_bus_if dut (
        .CLK       (CLK),
        .RST       (RST),
        .HOST_EN   (HOST_EN),
        .HOST_WE   (HOST_WE),
        .HOST_SEL  (HOST_SEL),
        .HOST_ADDR (HOST_ADDR),
        .HOST_DIN  (HOST_DIN),
        .HOST_DOUT (HOST_DOUT),
        .CLK_IDX   (CLK_IDX),
        .CLK_DOUT  (CLK_DOUT),
        .CNT_ADDR  (CNT_ADDR),
        .CNT_WE    (CNT_WE),
        .CNT_DIN   (CNT_DIN),
        .CNT_DOUT  (CNT_DOUT),
        .DUTY_IDX  (DUTY_IDX),
        .DUTY_DOUT (DUTY_DOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_wr(input logic [1:0] sel, input logic [13:0] addr,
                           input logic [15:0] data);
        HOST_EN = 1'b1; HOST_WE = 1'b1;
        HOST_SEL = sel; HOST_ADDR = addr; HOST_DIN = data;
        tick();
        HOST_EN = 1'b0; HOST_WE = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] sel, input logic [13:0] addr,
                           output logic [15:0] data);
        HOST_EN = 1'b1; HOST_WE = 1'b0;
        HOST_SEL = sel; HOST_ADDR = addr;
        tick();
        HOST_EN = 1'b0;
        data = HOST_DOUT;
    endtask

    initial begin
        // Reset held two cycles
        tick();
        tick();
        check("rst_host_dout", HOST_DOUT, 16'h0000);
        check("rst_clk_dout",  CLK_DOUT,  16'h0000);
        check("rst_cnt_dout",  CNT_DOUT,  16'h0000);
        check("rst_duty_dout", DUTY_DOUT, 16'h0000);
        RST = 1'b0;
        tick();
        check("cnt5_port", CNT_DOUT, 16'h0000);
        host_rd(2'd0, 14'd5, rd);
        check("cnt5_host", rd, 16'h0000);

        // Clock table
        host_wr(2'd1, 14'd0, 16'h03cf);
        host_wr(2'd1, 14'd1, 16'h3a28);
        CLK_IDX = 6'd1;
        tick();
        check("clk_idx1", CLK_DOUT, 16'h3a28);
        host_rd(2'd1, 14'd0, rd);
        check("clk_host0", rd, 16'h03cf);
        tick();
        check("host_hold", HOST_DOUT, 16'h03cf);

        // Duty table, top address and wrap
        host_wr(2'd2, 14'd1023, 16'h00ff);
        DUTY_IDX = 10'd1023;
        tick();
        check("duty_1023", DUTY_DOUT, 16'h00ff);
        host_wr(2'd2, 14'd1029, 16'hbeef);
        DUTY_IDX = 10'd5;
        tick();
        check("duty_wrap5", DUTY_DOUT, 16'hbeef);
        host_rd(2'd2, 14'd5, rd);
        check("duty_host5", rd, 16'hbeef);

        // Collision on cnt 3, read-before-write on consumer port
        CNT_ADDR = 6'd3; CNT_WE = 1'b1; CNT_DIN = 16'h5555;
        HOST_EN = 1'b1; HOST_WE = 1'b1;
        HOST_SEL = 2'd0; HOST_ADDR = 14'd3; HOST_DIN = 16'hAAAA;
        tick();
        HOST_EN = 1'b0; HOST_WE = 1'b0; CNT_WE = 1'b0;
        check("cnt3_rbw", CNT_DOUT, 16'h0000);
        tick();
        check("cnt3_port", CNT_DOUT, 16'hAAAA);
        host_rd(2'd0, 14'd3, rd);
        check("cnt3_host", rd, 16'hAAAA);

        // Different addresses same cycle
        CNT_ADDR = 6'd8; CNT_WE = 1'b1; CNT_DIN = 16'h2222;
        host_wr(2'd0, 14'd7, 16'h1111);
        CNT_WE = 1'b0;
        host_rd(2'd0, 14'd7, rd);
        check("cnt7_host", rd, 16'h1111);
        check("cnt8_port", CNT_DOUT, 16'h2222);

        // Reserved select
        host_wr(2'd3, 14'd0, 16'h1234);
        host_rd(2'd3, 14'd0, rd);
        check("rsv_read", rd, 16'h0000);
        host_rd(2'd1, 14'd0, rd);
        check("rsv_clk0", rd, 16'h03cf);
        host_rd(2'd0, 14'd0, rd);
        check("rsv_cnt0", rd, 16'h0000);
        host_rd(2'd2, 14'd0 + 14'd1029, rd);
        check("rsv_duty5", rd, 16'hbeef);

        // Reset with a write attempt; tables retained, cnt cleared
        CLK_IDX = 6'd0;
        RST = 1'b1;
        HOST_EN = 1'b1; HOST_WE = 1'b1;
        HOST_SEL = 2'd1; HOST_ADDR = 14'd0; HOST_DIN = 16'hdead;
        tick();
        HOST_EN = 1'b0; HOST_WE = 1'b0;
        tick();
        check("rst2_clk_dout",  CLK_DOUT,  16'h0000);
        check("rst2_host_dout", HOST_DOUT, 16'h0000);
        RST = 1'b0;
        CNT_ADDR = 6'd3;
        tick();
        check("ret_clk0", CLK_DOUT, 16'h03cf);
        check("rst2_cnt3", CNT_DOUT, 16'h0000);
        host_rd(2'd2, 14'd1023, rd);
        check("ret_duty1023", rd, 16'h00ff);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
